// File: rtl/max_scan_ctrl.sv
// Streaming unsigned max over a multi-beat vector: each LANES-wide beat is reduced
// by a combinational max tree, and a running max plus first-winning beat index is kept.
module max_scan_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int LANES      = 16,
   parameter int MAX_BEATS  = 64,
   parameter int CNT_W      = $clog2(MAX_BEATS) + 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [CNT_W-1:0]            num_beats,
   output logic                        busy,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [LANES*DATA_WIDTH-1:0] in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_WIDTH-1:0]       out_max,
   output logic [CNT_W-1:0]            out_beat_idx
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [CNT_W-1:0] MAX_B = CNT_W'(MAX_BEATS);

   state_t                         state, state_nxt;
   logic [CNT_W-1:0]               len, beat_cnt, idx_reg;
   logic [DATA_WIDTH-1:0]          max_reg, beat_max;
   logic [LANES-1:0][DATA_WIDTH-1:0] tree;
   logic                           accept, last;

   // Pairwise reduction, log2(LANES) levels deep; slot 0 ends up holding the beat max.
   always_comb begin
      for (int j = 0; j < LANES; j++)
         tree[j] = in_data[j*DATA_WIDTH +: DATA_WIDTH];
      for (int s = 1; s < LANES; s = s * 2)
         for (int j = 0; j + s < LANES; j = j + 2 * s)
            if (tree[j+s] > tree[j])
               tree[j] = tree[j+s];
      beat_max = tree[0];
   end

   assign in_ready     = (state == SCAN);
   assign busy         = (state != IDLE);
   assign out_valid    = (state == DONE);
   assign out_max      = max_reg;
   assign out_beat_idx = idx_reg;
   assign accept       = in_valid && in_ready;
   assign last         = (beat_cnt == len - CNT_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (num_beats == '0) ? DONE : SCAN;
         SCAN:    if (accept && last) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len      <= '0;
         beat_cnt <= '0;
         max_reg  <= '0;
         idx_reg  <= '0;
      end else if (state == IDLE && start) begin
         len      <= (num_beats > MAX_B) ? MAX_B : num_beats;
         beat_cnt <= '0;
         max_reg  <= '0;
         idx_reg  <= '0;
      end else if (accept) begin
         // Strict compare so a tie keeps the earlier beat index.
         if (beat_cnt == '0 || beat_max > max_reg) begin
            max_reg <= beat_max;
            idx_reg <= beat_cnt;
         end
         if (!last) beat_cnt <= beat_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_max_scan_ctrl.sv
// Directed bench for max_scan_ctrl (LANES=4, 8-bit elements, MAX_BEATS=8); a
// queue-based scoreboard checks every result handshake.
module tb_max_scan_ctrl;

   localparam int DW = 8, LN = 4, MB = 8, CW = 4;

   logic            clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [CW-1:0]   num_beats = '0;
   logic            busy, in_ready, out_valid;
   logic [LN*DW-1:0] in_data = '0;
   logic [DW-1:0]   out_max;
   logic [CW-1:0]   out_beat_idx;

   logic [31:0]       beat_mem [0:15];
   logic [DW+CW-1:0]  exp_q [$];
   logic [DW+CW-1:0]  e;
   int n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   max_scan_ctrl #(.DATA_WIDTH(DW), .LANES(LN), .MAX_BEATS(MB), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .num_beats(num_beats), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
      .out_beat_idx(out_beat_idx)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: result is consumed on the edge following this sample.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         chk("result_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_max", 32'(out_max), 32'(e[DW+CW-1:CW]));
            chk("out_beat_idx", 32'(out_beat_idx), 32'(e[CW-1:0]));
         end
      end
   end

   task automatic run_scan(input string nm, input int nb, input int nsend, input bit bub,
                           input logic [DW-1:0] emax, input logic [CW-1:0] eidx,
                           input int elat, input int hold, input bit poke);
      int sent = 0;
      int cyc;
      bit acc;
      exp_q.push_back({emax, eidx});
      start = 1'b1;
      num_beats = CW'(nb);
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 100) begin
         in_valid = bub ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = in_valid ? beat_mem[sent] : '1;
         start    = poke && (cyc == 1);
         if (poke && cyc == 1) num_beats = CW'(6);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) sent++;
         cyc++;
      end
      in_valid = 1'b0;
      start = 1'b0;
      chk({nm, " beats_consumed"}, 32'(sent), 32'(nsend));
      if (elat > 0) chk({nm, " latency"}, 32'(cyc), 32'(elat));
      for (int i = 0; i < hold; i++) begin
         chk({nm, " hold_valid"}, 32'(out_valid), 32'd1);
         chk({nm, " hold_max"}, 32'(out_max), 32'(emax));
         chk({nm, " hold_idx"}, 32'(out_beat_idx), 32'(eidx));
         chk({nm, " hold_in_ready"}, 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, " idle_valid"}, 32'(out_valid), 32'd0);
      chk({nm, " idle_busy"}, 32'(busy), 32'd0);
      chk({nm, " idle_max_kept"}, 32'(out_max), 32'(emax));
   endtask

   initial begin
      for (int i = 0; i < 16; i++) beat_mem[i] = '0;
      #12;
      chk("rst in_ready", 32'(in_ready), 32'd0);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst out_max", 32'(out_max), 32'd0);
      chk("rst out_beat_idx", 32'(out_beat_idx), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      beat_mem[0] = 32'h04030201; beat_mem[1] = 32'h00000009; beat_mem[2] = 32'h05050505;
      run_scan("basic", 3, 3, 1'b0, 8'h09, 4'd1, 4, 0, 1'b0);

      beat_mem[0] = 32'h07000000; beat_mem[1] = 32'h00070100; beat_mem[2] = 32'h00000003;
      run_scan("tie", 3, 3, 1'b0, 8'h07, 4'd0, 4, 5, 1'b0);

      beat_mem[0] = 32'h0; beat_mem[1] = 32'h0;
      run_scan("all_zero", 2, 2, 1'b0, 8'h00, 4'd0, 3, 0, 1'b0);

      beat_mem[0] = 32'h11223344; beat_mem[1] = 32'h00000050; beat_mem[2] = 32'h4F4F4F4F;
      beat_mem[3] = 32'h50000000; beat_mem[4] = 32'h0A0B0C0D;
      run_scan("bubbles", 5, 5, 1'b1, 8'h50, 4'd1, 0, 0, 1'b0);

      run_scan("num_beats0", 0, 0, 1'b0, 8'h00, 4'd0, 1, 0, 1'b0);

      for (int i = 0; i < 7; i++) beat_mem[i] = 32'h10203040;
      beat_mem[7] = 32'h00FF0000;
      for (int i = 8; i < 16; i++) beat_mem[i] = 32'hFEFEFEFE;
      run_scan("max_len", MB + 5, MB, 1'b0, 8'hFF, 4'd7, MB + 1, 0, 1'b0);

      beat_mem[0] = 32'h00000020; beat_mem[1] = 32'h00300000;
      run_scan("start_in_scan", 2, 2, 1'b0, 8'h30, 4'd1, 3, 0, 1'b1);

      // Abort a 4-beat scan after two beats, then confirm a clean follow-up scan.
      start = 1'b1; num_beats = 4'd4;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; in_data = 32'hF0F0F0F0;
      @(posedge clk); #1;
      in_data = 32'h00F10000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst in_ready", 32'(in_ready), 32'd0);
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst out_max", 32'(out_max), 32'd0);
      chk("midrst out_beat_idx", 32'(out_beat_idx), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      beat_mem[0] = 32'h00000003; beat_mem[1] = 32'h00000102;
      run_scan("post_rst", 2, 2, 1'b0, 8'h03, 4'd0, 3, 0, 1'b0);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
